lsu_mem_ctrl: RTL and testbench

- Load/store unit sitting between the execute stage and the word-only data memory (sync read, 1-cycle read latency, word write, internal addr>>2).
- Performs sub-word load extraction (sign/zero), SB/SH via read-modify-write, alignment/range/funct3 checking.
- Returns a stall (busy) and a completion pulse to the pipeline.

---
 rtl/lsu_mem_ctrl.sv | 223 ++++++++++++++++++++++
 tb/tb_lsu_mem_ctrl.sv | 322 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lsu_mem_ctrl.sv
// Load/store unit between the execute stage and a word-only synchronous data
// memory. Handles sub-word loads (sign/zero extension), byte/half stores via
// read-modify-write, and request checking (funct3, alignment, address range).
module lsu_mem_ctrl #(
  parameter int XLEN            = 32,
  parameter int MEM_DEPTH_WORDS = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            lsu_req_i,
  input  logic            lsu_we_i,
  input  logic [2:0]      lsu_funct3_i,
  input  logic [XLEN-1:0] lsu_addr_i,
  input  logic [XLEN-1:0] lsu_wdata_i,
  output logic            lsu_busy_o,
  output logic            lsu_done_o,
  output logic [XLEN-1:0] lsu_rdata_o,
  output logic [1:0]      lsu_err_o,
  output logic            mem_sel_o,
  output logic            mem_wen_o,
  output logic [XLEN-1:0] mem_addr_o,
  output logic [XLEN-1:0] mem_wdata_o,
  input  logic [XLEN-1:0] mem_rdata_i
);

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RD   = 2'b01,
    RESP = 2'b10,
    WR   = 2'b11
  } state_t;

  localparam logic [XLEN-1:0] MEM_BYTES = XLEN'(MEM_DEPTH_WORDS * 4);

  localparam logic [1:0] ERR_OK       = 2'b00;
  localparam logic [1:0] ERR_MISALIGN = 2'b01;
  localparam logic [1:0] ERR_RANGE    = 2'b10;
  localparam logic [1:0] ERR_ILLEGAL  = 2'b11;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  state_t            state_q,  state_d;
  logic [XLEN-1:0]   addr_q,   addr_d;
  logic [XLEN-1:0]   wdata_q,  wdata_d;
  logic [2:0]        funct3_q, funct3_d;
  logic              we_q,     we_d;
  logic              done_q,   done_d;
  logic [1:0]        err_q,    err_d;
  logic [XLEN-1:0]   rdata_q,  rdata_d;
  logic [1:0]        req_err;
  logic [XLEN-1:0]   word_addr;

  // Classify a request; illegal funct3 wins over misalignment, which wins over range.
  function automatic logic [1:0] check_req(input logic            we,
                                           input logic [2:0]      f3,
                                           input logic [XLEN-1:0] addr);
    logic legal;
    logic misaligned;
    if (we) legal = (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W);
    else    legal = (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W) ||
                    (f3 == F3_BU) || (f3 == F3_HU);
    misaligned = ((f3[1:0] == 2'b01) && addr[0]) ||
                 ((f3[1:0] == 2'b10) && (addr[1:0] != 2'b00));
    if (!legal)                  return ERR_ILLEGAL;
    else if (misaligned)         return ERR_MISALIGN;
    else if (addr >= MEM_BYTES)  return ERR_RANGE;
    else                         return ERR_OK;
  endfunction

  // Pull the addressed byte/half out of a little-endian word and extend it.
  function automatic logic [XLEN-1:0] load_extract(input logic [XLEN-1:0] word,
                                                   input logic [2:0]      f3,
                                                   input logic [1:0]      off);
    logic [7:0]  b;
    logic [15:0] h;
    case (off)
      2'b00:   b = word[7:0];
      2'b01:   b = word[15:8];
      2'b10:   b = word[23:16];
      default: b = word[31:24];
    endcase
    h = off[1] ? word[31:16] : word[15:0];
    case (f3)
      F3_B:    return {{(XLEN-8){b[7]}}, b};
      F3_BU:   return {{(XLEN-8){1'b0}}, b};
      F3_H:    return {{(XLEN-16){h[15]}}, h};
      F3_HU:   return {{(XLEN-16){1'b0}}, h};
      default: return word;
    endcase
  endfunction

  // Replace the addressed byte/half of the old word with store data; full word for SW.
  function automatic logic [XLEN-1:0] store_merge(input logic [XLEN-1:0] old,
                                                  input logic [1:0]      size,
                                                  input logic [1:0]      off,
                                                  input logic [XLEN-1:0] wd);
    logic [XLEN-1:0] w;
    w = old;
    if (size == 2'b00) begin
      case (off)
        2'b00:   w[7:0]   = wd[7:0];
        2'b01:   w[15:8]  = wd[7:0];
        2'b10:   w[23:16] = wd[7:0];
        default: w[31:24] = wd[7:0];
      endcase
    end else if (size == 2'b01) begin
      if (off[1]) w[31:16] = wd[15:0];
      else        w[15:0]  = wd[15:0];
    end else begin
      w = wd;
    end
    return w;
  endfunction

  // Check the incoming request against the live inputs (used only at acceptance).
  always_comb begin
    req_err = check_req(lsu_we_i, lsu_funct3_i, lsu_addr_i);
  end

  // Next-state logic: acceptance/latching, state sequencing, completion and load result.
  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    funct3_d = funct3_q;
    we_d     = we_q;
    done_d   = 1'b0;
    err_d    = err_q;
    rdata_d  = rdata_q;
    case (state_q)
      IDLE: begin
        if (lsu_req_i) begin
          addr_d   = lsu_addr_i;
          wdata_d  = lsu_wdata_i;
          funct3_d = lsu_funct3_i;
          we_d     = lsu_we_i;
          if (req_err != ERR_OK) begin
            // Rejected requests complete immediately without touching memory.
            done_d = 1'b1;
            err_d  = req_err;
          end else if (lsu_we_i && (lsu_funct3_i[1:0] == 2'b10)) begin
            state_d = WR;
          end else begin
            state_d = RD;
          end
        end
      end
      RD: begin
        // Sub-word stores read the word first and merge during WR.
        state_d = we_q ? WR : RESP;
      end
      RESP: begin
        rdata_d = load_extract(mem_rdata_i, funct3_q, addr_q[1:0]);
        done_d  = 1'b1;
        err_d   = ERR_OK;
        state_d = IDLE;
      end
      WR: begin
        done_d  = 1'b1;
        err_d   = ERR_OK;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State and request registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      addr_q   <= '0;
      wdata_q  <= '0;
      funct3_q <= '0;
      we_q     <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= ERR_OK;
      rdata_q  <= '0;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      funct3_q <= funct3_d;
      we_q     <= we_d;
      done_q   <= done_d;
      err_q    <= err_d;
      rdata_q  <= rdata_d;
    end
  end

  assign word_addr = {addr_q[XLEN-1:2], 2'b00};

  // Memory interface decode; everything is zero outside the RD and WR states.
  always_comb begin
    mem_sel_o   = 1'b0;
    mem_wen_o   = 1'b0;
    mem_addr_o  = '0;
    mem_wdata_o = '0;
    case (state_q)
      RD: begin
        mem_sel_o  = 1'b1;
        mem_addr_o = word_addr;
      end
      WR: begin
        mem_sel_o   = 1'b1;
        mem_wen_o   = 1'b1;
        mem_addr_o  = word_addr;
        // For SB/SH the read data from the preceding RD cycle is valid now.
        mem_wdata_o = store_merge(mem_rdata_i, funct3_q[1:0], addr_q[1:0], wdata_q);
      end
      default: ;
    endcase
  end

  assign lsu_busy_o  = (state_q != IDLE);
  assign lsu_done_o  = done_q;
  assign lsu_err_o   = err_q;
  assign lsu_rdata_o = rdata_q;

endmodule

// File: tb/tb_lsu_mem_ctrl.sv
// Bench for lsu_mem_ctrl: word memory model, reference memory and a scoreboard
// of expected completions pushed at acceptance and popped on done.
module tb_lsu_mem_ctrl;

  localparam int DEPTH = 32;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        lsu_req_i = 1'b0;
  logic        lsu_we_i = 1'b0;
  logic [2:0]  lsu_funct3_i = 3'b0;
  logic [31:0] lsu_addr_i = 32'h0;
  logic [31:0] lsu_wdata_i = 32'h0;
  logic        lsu_busy_o;
  logic        lsu_done_o;
  logic [31:0] lsu_rdata_o;
  logic [1:0]  lsu_err_o;
  logic        mem_sel_o;
  logic        mem_wen_o;
  logic [31:0] mem_addr_o;
  logic [31:0] mem_wdata_o;
  logic [31:0] mem_rdata_i = 32'h0;

  always #5 clk = ~clk;

  lsu_mem_ctrl #(.XLEN(32), .MEM_DEPTH_WORDS(DEPTH)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .lsu_req_i    (lsu_req_i),
    .lsu_we_i     (lsu_we_i),
    .lsu_funct3_i (lsu_funct3_i),
    .lsu_addr_i   (lsu_addr_i),
    .lsu_wdata_i  (lsu_wdata_i),
    .lsu_busy_o   (lsu_busy_o),
    .lsu_done_o   (lsu_done_o),
    .lsu_rdata_o  (lsu_rdata_o),
    .lsu_err_o    (lsu_err_o),
    .mem_sel_o    (mem_sel_o),
    .mem_wen_o    (mem_wen_o),
    .mem_addr_o   (mem_addr_o),
    .mem_wdata_o  (mem_wdata_o),
    .mem_rdata_i  (mem_rdata_i)
  );

  typedef struct {
    logic        we;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [1:0]  err;
    int          due;
  } exp_t;

  exp_t        q[$];
  exp_t        mon_e;
  logic [31:0] mem [DEPTH];
  logic [31:0] ref_mem [DEPTH];
  logic        mem_loaded = 1'b0;
  logic        ref_loaded = 1'b0;
  logic [31:0] exp_rdata = 32'h0;
  int          cyc = 0;
  int          n_checks = 0;
  int          n_errors = 0;
  int          n_wr = 0;
  int          exp_wr = 0;
  int          n_acc = 0;
  int          n_done = 0;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h, want 0x%08h (cycle %0d)", tag, act, exp, cyc);
    end
  endtask

  // Reference behaviour
  function automatic logic [1:0] m_err(input logic we, input logic [2:0] f3, input logic [31:0] a);
    logic ok;
    ok = we ? (f3 <= 3'd2) : (f3 <= 3'd2 || f3 == 3'd4 || f3 == 3'd5);
    if (!ok) return 2'b11;
    if ((f3[1:0] == 2'b01 && a[0]) || (f3[1:0] == 2'b10 && a[1:0] != 2'b00)) return 2'b01;
    if (a >= 32'(DEPTH * 4)) return 2'b10;
    return 2'b00;
  endfunction

  function automatic int m_lat(input logic we, input logic [2:0] f3, input logic [1:0] err);
    if (err != 2'b00) return 1;
    if (we && f3 == 3'd2) return 2;
    return 3;
  endfunction

  function automatic logic [31:0] m_load(input logic [31:0] w, input logic [2:0] f3, input logic [31:0] a);
    logic [7:0]  b;
    logic [15:0] h;
    b = 8'(w >> (8 * a[1:0]));
    h = 16'(w >> (16 * a[1]));
    case (f3)
      3'd0:    return 32'($signed(b));
      3'd4:    return 32'(b);
      3'd1:    return 32'($signed(h));
      3'd5:    return 32'(h);
      default: return w;
    endcase
  endfunction

  function automatic logic [31:0] m_store(input logic [31:0] old, input logic [2:0] f3,
                                          input logic [31:0] a, input logic [31:0] wd);
    logic [31:0] mask;
    logic [31:0] data;
    if (f3 == 3'd0) begin
      mask = 32'hff << (8 * a[1:0]);
      data = (wd & 32'hff) << (8 * a[1:0]);
    end else if (f3 == 3'd1) begin
      mask = 32'hffff << (16 * a[1]);
      data = (wd & 32'hffff) << (16 * a[1]);
    end else begin
      mask = 32'hffffffff;
      data = wd;
    end
    return (old & ~mask) | (data & mask);
  endfunction

  // Word memory: synchronous read, one-cycle latency
  always @(posedge clk) begin
    if (!mem_loaded) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= 32'h0;
      mem[0] <= 32'hff0000ff;
      mem[1] <= 32'hf00f0ff0;
      mem_loaded <= 1'b1;
    end else if (mem_sel_o) begin
      if (mem_wen_o) mem[mem_addr_o[6:2]] <= mem_wdata_o;
      else           mem_rdata_i <= mem[mem_addr_o[6:2]];
    end
  end

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor / scoreboard
  always @(negedge clk) begin
    if (!ref_loaded) begin
      for (int i = 0; i < DEPTH; i++) ref_mem[i] = 32'h0;
      ref_mem[0] = 32'hff0000ff;
      ref_mem[1] = 32'hf00f0ff0;
      ref_loaded = 1'b1;
    end
    if (mem_sel_o) begin
      check_eq("sel_for_valid_req", 32'(q.size() != 0 && q[0].err == 2'b00), 32'd1);
      if (q.size() != 0) begin
        mon_e = q[0];
        check_eq("mem_addr", mem_addr_o, {mon_e.addr[31:2], 2'b00});
        if (mem_wen_o) begin
          n_wr++;
          check_eq("mem_wdata", mem_wdata_o,
                   m_store(ref_mem[mon_e.addr[6:2]], mon_e.f3, mon_e.addr, mon_e.wdata));
        end
      end
    end
    if (lsu_done_o) begin
      n_done++;
      if (q.size() == 0) begin
        check_eq("spurious_done_pending", 32'(q.size()), 32'd1);
      end else begin
        mon_e = q.pop_front();
        check_eq("done_latency", 32'(cyc), 32'(mon_e.due));
        check_eq("err", 32'(lsu_err_o), 32'(mon_e.err));
        if (mon_e.err == 2'b00) begin
          if (mon_e.we) begin
            ref_mem[mon_e.addr[6:2]] = m_store(ref_mem[mon_e.addr[6:2]], mon_e.f3, mon_e.addr, mon_e.wdata);
            exp_wr++;
          end else begin
            exp_rdata = m_load(ref_mem[mon_e.addr[6:2]], mon_e.f3, mon_e.addr);
          end
        end
        check_eq("rdata", lsu_rdata_o, exp_rdata);
      end
    end else if (q.size() != 0 && cyc > q[0].due) begin
      check_eq("missing_done", 32'(cyc), 32'(q[0].due));
      void'(q.pop_front());
    end
    if (!rst_n) begin
      n_acc -= q.size();
      q.delete();
      exp_rdata = 32'h0;
    end else if (lsu_req_i && !lsu_busy_o) begin
      mon_e.we    = lsu_we_i;
      mon_e.f3    = lsu_funct3_i;
      mon_e.addr  = lsu_addr_i;
      mon_e.wdata = lsu_wdata_i;
      mon_e.err   = m_err(lsu_we_i, lsu_funct3_i, lsu_addr_i);
      mon_e.due   = cyc + m_lat(lsu_we_i, lsu_funct3_i, mon_e.err);
      q.push_back(mon_e);
      n_acc++;
    end
  end

  // Drive one request and release it after the acceptance edge.
  task automatic send(input logic we, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] wd);
    int n;
    lsu_we_i     = we;
    lsu_funct3_i = f3;
    lsu_addr_i   = a;
    lsu_wdata_i  = wd;
    lsu_req_i    = 1'b1;
    n = 0;
    @(negedge clk);
    while (lsu_busy_o && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (n >= 40) check_eq("accept_busy", 32'(lsu_busy_o), 32'd0);
    @(posedge clk);
    #1;
    lsu_req_i = 1'b0;
  endtask

  task automatic idle_wait();
    int n;
    n = 0;
    while ((q.size() != 0 || lsu_busy_o) && n < 40) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (n >= 40) check_eq("idle_timeout_pending", 32'(q.size()), 32'd0);
  endtask

  task automatic check_all_zero(input string tag);
    check_eq({tag, "_busy"},  32'(lsu_busy_o), 32'd0);
    check_eq({tag, "_done"},  32'(lsu_done_o), 32'd0);
    check_eq({tag, "_rdata"}, lsu_rdata_o, 32'h0);
    check_eq({tag, "_err"},   32'(lsu_err_o), 32'd0);
    check_eq({tag, "_sel"},   32'(mem_sel_o), 32'd0);
    check_eq({tag, "_wen"},   32'(mem_wen_o), 32'd0);
    check_eq({tag, "_addr"},  mem_addr_o, 32'h0);
    check_eq({tag, "_wdata"}, mem_wdata_o, 32'h0);
  endtask

  initial begin
    int wr_before;
    repeat (3) @(posedge clk);
    #1;
    check_all_zero("reset");
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Loads from preloaded words
    send(1'b0, 3'd2, 32'h4, 32'h0); idle_wait();
    check_eq("lw_0x4", lsu_rdata_o, 32'hf00f0ff0);
    send(1'b0, 3'd0, 32'h0, 32'h0); idle_wait();
    check_eq("lb_0x0", lsu_rdata_o, 32'hffffffff);
    send(1'b0, 3'd4, 32'h1, 32'h0); idle_wait();
    check_eq("lbu_0x1", lsu_rdata_o, 32'h00000000);
    send(1'b0, 3'd1, 32'h6, 32'h0); idle_wait();
    check_eq("lh_0x6", lsu_rdata_o, 32'hfffff00f);

    // Byte store via read-modify-write
    send(1'b1, 3'd0, 32'h1, 32'h12345); idle_wait();
    send(1'b0, 3'd2, 32'h0, 32'h0); idle_wait();
    check_eq("lw_after_sb", lsu_rdata_o, 32'hff0045ff);

    // SH then SW back-to-back: second request raised in the first done cycle
    send(1'b1, 3'd1, 32'h6, 32'h0000abcd);
    repeat (2) @(posedge clk);
    #1;
    send(1'b1, 3'd2, 32'h8, 32'hdeadbeef); idle_wait();
    check_eq("word1_after_sh", mem[1], 32'habcd0ff0);
    check_eq("word2_after_sw", mem[2], 32'hdeadbeef);
    send(1'b0, 3'd5, 32'h6, 32'h0); idle_wait();
    check_eq("lhu_0x6", lsu_rdata_o, 32'h0000abcd);

    // Rejected requests (rdata must stay at the last load result)
    send(1'b0, 3'd2, 32'h2,  32'h0); idle_wait();
    send(1'b1, 3'd1, 32'h3,  32'h0); idle_wait();
    send(1'b0, 3'd2, 32'h80, 32'h0); idle_wait();
    send(1'b0, 3'd3, 32'h0,  32'h0); idle_wait();
    send(1'b0, 3'd3, 32'h83, 32'h0); idle_wait();
    send(1'b1, 3'd4, 32'h0,  32'h0); idle_wait();
    send(1'b0, 3'd2, 32'h82, 32'h0); idle_wait();
    send(1'b1, 3'd2, 32'h7c, 32'h0); idle_wait();
    check_eq("rdata_held_after_errors", lsu_rdata_o, 32'h0000abcd);

    // Request held high across busy cycles
    lsu_we_i = 1'b0; lsu_funct3_i = 3'd2; lsu_addr_i = 32'h4; lsu_req_i = 1'b1;
    repeat (7) @(posedge clk);
    #1;
    lsu_req_i = 1'b0;
    idle_wait();

    // Small random mix
    for (int i = 0; i < 16; i++) begin
      send(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)),
           32'($urandom_range(0, 32'h8f)), $urandom);
      idle_wait();
    end

    // Reset while an SB is in its RD cycle
    wr_before = n_wr;
    send(1'b1, 3'd0, 32'h0, 32'h99);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    check_all_zero("abort");
    repeat (4) @(posedge clk);
    #1;
    check_eq("abort_no_write", 32'(n_wr), 32'(wr_before));
    send(1'b0, 3'd2, 32'h0, 32'h0); idle_wait();

    repeat (2) @(posedge clk);
    #1;
    check_eq("queue_empty", 32'(q.size()), 32'd0);
    check_eq("write_count", 32'(n_wr), 32'(exp_wr));
    check_eq("done_count", 32'(n_done), 32'(n_acc));
    for (int i = 0; i < 4; i++) check_eq("mem_final", mem[i], ref_mem[i]);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
